packet_assembler: RTL and testbench
===================================

// Module: packet_assembler
// PURPOSE
//  Downstream of the packet picker in the HDMI data-island path. Receives the picked packet
//  (24-bit header, 4x56-bit subpackets) and serialises it over 32 pixel clocks, appending BCH ECC.
//  Emits 9 bits/pixel to the TERC4 channel encoders. Owns the packet pixel counter and the
//  packet_enable strobe that tells the picker when to choose the next packet.
// PARAMETERS
//  (none; all geometry constants come from hdmi_pkg)
// PORTS
//  clk_pixel            in   1       pixel clock; the only clock
//  reset_n              in   1       synchronous, active-low reset
//  data_island_period   in   1       high on every pixel clock of a data island (multiple of 32)
//  header               in   24      packet header HB2..HB0 from picker
//  sub                  in   4x56    subpackets 0..3 from picker
//  packet_data          out  9       [0]=ch0 bit2; [4:1]=sub0..3 even bit (ch1); [8:5]=sub0..3 odd bit (ch2)
//  packet_pixel_counter out  5       index of pixel in current packet, 0..31
//  packet_enable        out  1       picker may change packet: counter==31 && data_island_period
// BEHAVIOUR
//  - Reset (reset_n==0 at clk edge): counter=0, ecc regs=0, shadow regs=0, packet_data=9'd0; packet_enable=0.
//  - Counter: +1 per clk while data_island_period, wraps 31->0; forced to 0 when data_island_period low.
//  - packet_enable combinational from counter and data_island_period; never high outside an island.
//  - Capture: at counter==0 in-island, header/sub sampled into shadow regs; bits for pixel 0 taken
//    directly from inputs that cycle, pixels 1..31 from shadow. Input changes after pixel 0 ignored.
//  - Latency: packet_data is registered; value for pixel c appears cycle after counter==c.
//  - Header lane: pixels 0..23 emit header[c]; pixels 24..31 emit header ECC bit (c-24).
//  - Sub lanes (each k=0..3): pixels 0..27 emit sub[k][2c] on even lane, sub[k][2c+1] on odd lane;
//    pixels 28..31 emit ECC bits 2(c-28), 2(c-28)+1.
//  - BCH step per bit b: fb=ecc[0]^b; ecc=(ecc>>1) ^ (fb ? BCH_POLY : 0); BCH_POLY=8'h83.
//    Header ECC: 1 step/pixel over pixels 0..23. Sub ECC: 2 steps/pixel (even bit first) over 0..27.
//    All ECC regs cleared at counter==0 before the step (i.e. step starts from 0).
//  - Outside island: packet_data registered to 9'd0 the cycle after data_island_period falls.
//  - Island drop mid-packet (counter!=0): packet abandoned, counter->0, ECC discarded; next island
//    starts a fresh packet at pixel 0. No partial-packet completion.
//  - Reset mid-packet: identical to reset; output 0 next cycle.
//  - Back-to-back packets: pixel 31 of packet n and pixel 0 of packet n+1 on adjacent clks, no bubble.
// CONFIGURATION
//  - PACKET_ASSEMBLER_CHECK_EN defined: adds output protocol_error (1 bit, reset 0), pulses one cycle
//    when data_island_period falls with counter!=0, or when header/sub differ from shadow on
//    pixels 1..31 of a packet. Not defined: port and checker logic absent; behaviour otherwise identical.
// STRUCTURE
//  - hdmi_pkg: PACKET_PIXELS=32, HEADER_BITS=24, SUB_BITS=56, ECC_BITS=8, BCH_POLY=8'h83,
//    typedef logic [8:0] packet_data_t, typedef logic [55:0] subpacket_t.
//  - Sub-module bch_ecc_step #(BITS_PER_STEP=1|2): combinational ecc_next from ecc, data bits;
//    instantiated once for header (1) and four times for subs (2).
//  - Top: counter, shadow regs, 5 ECC regs, output mux + output register.
// TESTING
//  1 Null packet: header=0, sub=0, island 32 clks -> packet_data==0 all 32 pixels; packet_enable at ctr 31 only.
//  2 header=24'h800000, sub=0 -> ch0 bit high at pixel 23; ECC bits (pixels 24..31) = 8'h83 LSB first.
//  3 header=24'h400000 -> ECC = 8'hC2; sub[0]=56'h1 -> lane1 pixel 0 high; sub ECC matches bch model.
//  4 64-clk island, two different packets -> second ECC independent of first; no gap at 31->0 boundary.
//  5 Drop data_island_period at counter==10 -> counter 0, packet_data 0 next cycle; new island pixel 0 correct.
//  6 reset_n low at counter==17 -> all outputs 0 next cycle; with CHECK_EN, sub change at pixel 5 -> protocol_error pulse.

Source files
------------

// File: rtl/packet_assembler_pkg.sv
// Shared constants and types for the HDMI data-island packet assembler.
// Geometry: 32 pixels per packet, 24-bit header, four 56-bit subpackets,
// 8-bit BCH ECC per lane (generator 8'h83, LSB-first shift register).
package packet_assembler_pkg;
    localparam int PACKET_PIXELS = 32;
    localparam int HEADER_BITS   = 24;
    localparam int SUB_BITS      = 56;
    localparam int ECC_BITS      = 8;
    localparam int NUM_SUBS      = 4;
    localparam logic [ECC_BITS-1:0] BCH_POLY = 8'h83;

    typedef logic [8:0]          packet_data_t;
    typedef logic [55:0]         subpacket_t;
    typedef logic [4:0]          pixel_idx_t;
    typedef logic [ECC_BITS-1:0] ecc_t;
endpackage

// File: rtl/packet_assembler_if.sv
// Bus between the packet picker (master) and the packet assembler (slave).
//   data_island_period   picker -> assembler  high on every pixel of a data island
//   header[23:0]         picker -> assembler  HB2..HB0
//   sub[3:0]             picker -> assembler  subpackets 0..3, 56 bits each
//   packet_data[8:0]     assembler -> picker  TERC4 payload bits for this pixel
//   packet_pixel_counter assembler -> picker  pixel index 0..31 in current packet
//   packet_enable        assembler -> picker  picker may select the next packet
//   protocol_error       assembler -> picker  only with PACKET_ASSEMBLER_CHECK_EN
interface packet_assembler_if;
    import packet_assembler_pkg::*;

    logic                   data_island_period;
    logic [HEADER_BITS-1:0] header;
    subpacket_t [3:0]       sub;
    packet_data_t           packet_data;
    pixel_idx_t             packet_pixel_counter;
    logic                   packet_enable;
`ifdef PACKET_ASSEMBLER_CHECK_EN
    logic                   protocol_error;
`endif

    modport master (
        output data_island_period, header, sub,
        input  packet_data, packet_pixel_counter, packet_enable
`ifdef PACKET_ASSEMBLER_CHECK_EN
        , input protocol_error
`endif
    );

    modport slave (
        input  data_island_period, header, sub,
        output packet_data, packet_pixel_counter, packet_enable
`ifdef PACKET_ASSEMBLER_CHECK_EN
        , output protocol_error
`endif
    );
endinterface

// File: rtl/packet_assembler_bch_ecc_step.sv
// Combinational BCH ECC update over BITS_PER_STEP data bits, bit 0 first.
//   ecc_i   current ECC register value
//   data_i  data bits consumed this step (bit 0 processed first)
//   ecc_o   ECC after all bits are absorbed
module packet_assembler_bch_ecc_step
    import packet_assembler_pkg::*;
#(
    parameter int BITS_PER_STEP = 1
) (
    input  ecc_t                     ecc_i,
    input  logic [BITS_PER_STEP-1:0] data_i,
    output ecc_t                     ecc_o
);
    always_comb begin
        ecc_t acc;
        acc = ecc_i;
        for (int i = 0; i < BITS_PER_STEP; i++) begin
            if (acc[0] ^ data_i[i]) begin
                acc = (acc >> 1) ^ BCH_POLY;
            end else begin
                acc = acc >> 1;
            end
        end
        ecc_o = acc;
    end
endmodule

// File: rtl/packet_assembler.sv
// HDMI data-island packet assembler: serialises one picked packet (header +
// four subpackets) over 32 pixel clocks and appends BCH ECC per lane.
// Ports:
//   clk_pixel  pixel clock, the only clock
//   reset_n    synchronous active-low reset
//   bus        packet_assembler_if.slave (island strobe, header/sub in;
//              packet_data, packet_pixel_counter, packet_enable out)
// Build option: define PACKET_ASSEMBLER_CHECK_EN to add bus.protocol_error,
// a one-cycle pulse on a mid-packet island drop or on header/sub changing
// after pixel 0 of a packet.
module packet_assembler
    import packet_assembler_pkg::*;
(
    input logic                clk_pixel,
    input logic                reset_n,
    packet_assembler_if.slave  bus
);
    localparam pixel_idx_t HDR_PIXELS = pixel_idx_t'(HEADER_BITS);
    localparam pixel_idx_t SUB_PIXELS = pixel_idx_t'(SUB_BITS / 2);
    localparam pixel_idx_t LAST_PIXEL = pixel_idx_t'(PACKET_PIXELS - 1);

    pixel_idx_t             ctr_q, ctr_d;
    logic [HEADER_BITS-1:0] hdr_shadow_q, hdr_shadow_d, hdr_src;
    subpacket_t [3:0]       sub_shadow_q, sub_shadow_d, sub_src;
    ecc_t                   hdr_ecc_q, hdr_ecc_d, hdr_ecc_cur, hdr_ecc_step;
    ecc_t [3:0]             sub_ecc_q, sub_ecc_d, sub_ecc_cur, sub_ecc_step;
    packet_data_t           data_q, data_d;
    logic                   island, first_pixel;

    assign island      = bus.data_island_period;
    assign first_pixel = island && (ctr_q == '0);

    // Pixel 0 uses the live inputs (shadow not yet loaded); later pixels use the shadow.
    assign hdr_src = first_pixel ? bus.header : hdr_shadow_q;
    assign sub_src = first_pixel ? bus.sub    : sub_shadow_q;

    // ECC starts from zero at pixel 0 regardless of what the previous packet left.
    always_comb begin
        hdr_ecc_cur = first_pixel ? '0 : hdr_ecc_q;
        for (int k = 0; k < NUM_SUBS; k++) begin
            sub_ecc_cur[k] = first_pixel ? '0 : sub_ecc_q[k];
        end
    end

    packet_assembler_bch_ecc_step #(.BITS_PER_STEP(1)) u_hdr_ecc (
        .ecc_i  (hdr_ecc_cur),
        .data_i (hdr_src[ctr_q]),
        .ecc_o  (hdr_ecc_step)
    );

    for (genvar k = 0; k < NUM_SUBS; k++) begin : g_sub_ecc
        packet_assembler_bch_ecc_step #(.BITS_PER_STEP(2)) u_sub_ecc (
            .ecc_i  (sub_ecc_cur[k]),
            .data_i ({sub_src[k][{ctr_q, 1'b1}], sub_src[k][{ctr_q, 1'b0}]}),
            .ecc_o  (sub_ecc_step[k])
        );
    end

    always_comb begin
        ctr_d        = island ? ctr_q + 5'd1 : '0;  // 31 -> 0 wraps naturally
        hdr_shadow_d = first_pixel ? bus.header : hdr_shadow_q;
        sub_shadow_d = first_pixel ? bus.sub    : sub_shadow_q;
        hdr_ecc_d    = (island && ctr_q < HDR_PIXELS) ? hdr_ecc_step : hdr_ecc_q;
        sub_ecc_d    = sub_ecc_q;
        data_d       = '0;
        for (int k = 0; k < NUM_SUBS; k++) begin
            if (island && ctr_q < SUB_PIXELS) begin
                sub_ecc_d[k] = sub_ecc_step[k];
            end
        end
        if (island) begin
            // ECC bit index is c-24 / c-28; the low bits of c give it directly.
            data_d[0] = (ctr_q < HDR_PIXELS) ? hdr_src[ctr_q] : hdr_ecc_q[ctr_q[2:0]];
            for (int k = 0; k < NUM_SUBS; k++) begin
                if (ctr_q < SUB_PIXELS) begin
                    data_d[1+k] = sub_src[k][{ctr_q, 1'b0}];
                    data_d[5+k] = sub_src[k][{ctr_q, 1'b1}];
                end else begin
                    data_d[1+k] = sub_ecc_q[k][{ctr_q[1:0], 1'b0}];
                    data_d[5+k] = sub_ecc_q[k][{ctr_q[1:0], 1'b1}];
                end
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            ctr_q        <= '0;
            hdr_shadow_q <= '0;
            sub_shadow_q <= '0;
            hdr_ecc_q    <= '0;
            sub_ecc_q    <= '0;
            data_q       <= '0;
        end else begin
            ctr_q        <= ctr_d;
            hdr_shadow_q <= hdr_shadow_d;
            sub_shadow_q <= sub_shadow_d;
            hdr_ecc_q    <= hdr_ecc_d;
            sub_ecc_q    <= sub_ecc_d;
            data_q       <= data_d;
        end
    end

    assign bus.packet_data          = data_q;
    assign bus.packet_pixel_counter = ctr_q;
    assign bus.packet_enable        = island && (ctr_q == LAST_PIXEL);

`ifdef PACKET_ASSEMBLER_CHECK_EN
    logic perr_q, perr_d;

    always_comb begin
        perr_d = 1'b0;
        if (ctr_q != '0) begin
            if (!island) begin
                perr_d = 1'b1;
            end else if (bus.header != hdr_shadow_q || bus.sub != sub_shadow_q) begin
                perr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign bus.protocol_error = perr_q;
`endif
endmodule

// File: tb/tb_packet_assembler.sv
module tb_packet_assembler;
    import packet_assembler_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    packet_assembler_if bus ();

    packet_assembler dut (
        .clk_pixel (clk),
        .reset_n   (rst_n),
        .bus       (bus)
    );

    int           checks = 0;
    int           errors = 0;
    packet_data_t exp_q[$];
    packet_data_t pkt[32];
    packet_data_t got[32];

    logic [23:0]      h1, h2;
    subpacket_t [3:0] s0, s1, s2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic ecc_t bch(input logic [63:0] bits, input int n);
        ecc_t e = '0;
        for (int i = 0; i < n; i++) begin
            if (e[0] ^ bits[i]) e = {1'b0, e[7:1]} ^ 8'h83;
            else                e = {1'b0, e[7:1]};
        end
        return e;
    endfunction

    // Expected 32 output words for one packet, built from the full-stream ECC.
    task automatic build(input logic [23:0] h, input subpacket_t [3:0] s);
        ecc_t         he;
        ecc_t         se[4];
        packet_data_t w;
        he = bch({40'd0, h}, 24);
        for (int k = 0; k < 4; k++) se[k] = bch({8'd0, s[k]}, 56);
        for (int c = 0; c < 32; c++) begin
            w = '0;
            w[0] = (c < 24) ? h[c] : he[c-24];
            for (int k = 0; k < 4; k++) begin
                if (c < 28) begin
                    w[1+k] = s[k][2*c];
                    w[5+k] = s[k][2*c+1];
                end else begin
                    w[1+k] = se[k][2*(c-28)];
                    w[5+k] = se[k][2*(c-28)+1];
                end
            end
            pkt[c] = w;
        end
    endtask

    task automatic tick(input string tag);
        packet_data_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty observed=%0h", tag, bus.packet_data);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'(bus.packet_data), 32'(e));
        end
    endtask

    task automatic send(input logic [23:0] h, input subpacket_t [3:0] s, input int n,
                        input int glitch_at, input string tag);
        build(h, s);
        for (int c = 0; c < n; c++) begin
            bus.data_island_period = 1'b1;
            bus.header             = h;
            bus.sub                = s;
            if (c == glitch_at) begin
                bus.sub[2] = ~s[2];
                bus.header = h ^ 24'h1;
            end
            check({tag, "_ctr"}, 32'(bus.packet_pixel_counter), 32'(c));
            check({tag, "_en"}, 32'(bus.packet_enable), 32'(c == 31));
            exp_q.push_back(pkt[c]);
            tick({tag, "_data"});
            got[c] = bus.packet_data;
`ifdef PACKET_ASSEMBLER_CHECK_EN
            check({tag, "_perr"}, 32'(bus.protocol_error), 32'(c == glitch_at && c != 0));
`endif
        end
    endtask

    task automatic idle(input int n, input bit perr_first);
        for (int i = 0; i < n; i++) begin
            bus.data_island_period = 1'b0;
            bus.header             = '0;
            bus.sub                = '0;
            exp_q.push_back('0);
            tick("idle_data");
            check("idle_ctr", 32'(bus.packet_pixel_counter), 32'd0);
            check("idle_en", 32'(bus.packet_enable), 32'd0);
`ifdef PACKET_ASSEMBLER_CHECK_EN
            check("idle_perr", 32'(bus.protocol_error), 32'(i == 0 && perr_first));
`endif
        end
    endtask

    function automatic logic [7:0] hdr_ecc_seen();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = got[24+i][0];
        return b;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n                  = 1'b0;
        bus.data_island_period = 1'b0;
        bus.header             = '0;
        bus.sub                = '0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('0);
            tick("rst_data");
        end
        check("rst_ctr", 32'(bus.packet_pixel_counter), 32'd0);
        check("rst_en", 32'(bus.packet_enable), 32'd0);
        rst_n = 1'b1;
        idle(2, 1'b0);

        // Null packet
        s0 = '0;
        send(24'h0, s0, 32, -1, "null");
        idle(1, 1'b0);

        // Single header bit 23: ECC equals the generator
        send(24'h800000, s0, 32, -1, "hb23");
        check("hb23_px23", 32'(got[23][0]), 32'd1);
        check("hb23_ecc", 32'(hdr_ecc_seen()), 32'h83);
        idle(1, 1'b0);

        // Header bit 22 and sub0 bit 0
        s1    = '0;
        s1[0] = 56'h1;
        send(24'h400000, s1, 32, -1, "hb22");
        check("hb22_ecc", 32'(hdr_ecc_seen()), 32'hC2);
        check("sub0_px0", 32'(got[0][1]), 32'd1);
        idle(1, 1'b0);

        // Back-to-back random packets in one 64-clock island
        h1 = 24'($urandom);
        h2 = 24'($urandom);
        for (int k = 0; k < 4; k++) begin
            s1[k] = {24'($urandom), $urandom};
            s2[k] = {24'($urandom), $urandom};
        end
        send(h1, s1, 32, -1, "b2b_a");
        send(h2, s2, 32, -1, "b2b_b");
        idle(2, 1'b0);

        // Island drops at counter 10, then a fresh packet
        send(h2, s1, 10, -1, "drop");
        idle(3, 1'b1);
        send(h1, s2, 32, -1, "after_drop");

        // Reset mid-packet at counter 17 with the island still high
        send(h1, s1, 17, -1, "pre_rst");
        rst_n = 1'b0;
        bus.data_island_period = 1'b1;
        exp_q.push_back('0);
        tick("rst_mid_data");
        check("rst_mid_ctr", 32'(bus.packet_pixel_counter), 32'd0);
`ifdef PACKET_ASSEMBLER_CHECK_EN
        check("rst_mid_perr", 32'(bus.protocol_error), 32'd0);
`endif
        rst_n = 1'b1;
        idle(2, 1'b0);

        // Inputs changed at pixel 5: output must follow the captured packet
        send(h2, s2, 32, 5, "glitch");
        idle(1, 1'b0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
